// File: rtl/rx_pkt_ctrl_pkg.sv
// Shared definitions for the packet receive controller:
// FSM state encoding, frame field widths, header default.
package rx_pkt_ctrl_pkg;

   localparam logic [7:0] HEADER_DEF = 8'hAA;
   localparam int         BYTE_W     = 8;
   localparam int         LEN_W      = 5;
   localparam int         ADDR_W     = 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CSUM    = 3'd3,
      S_HOLD    = 3'd4
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/rx_pkt_buf.sv
// Payload buffer: DEPTH x 8, one write port, one registered read port.
// Ports: i_clk, i_rst_n, i_wr_en/i_wr_addr/i_wr_data, i_rd_addr, o_rd_data.
module rx_pkt_buf
   import rx_pkt_ctrl_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [BYTE_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [BYTE_W-1:0] o_rd_data
);

   logic [BYTE_W-1:0] r_mem [DEPTH];
   logic [BYTE_W-1:0] r_rd_data;

   // Storage itself is never cleared; only the read register resets.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rd_data <= '0;
      else          r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_pkt_ctrl.sv
// Framed packet receiver: HEADER, LEN, payload, CSUM; holds a checked
// packet for the consumer. Ports: i_clk, i_rst_n, i_rx_data/valid/err from
// UART, o_rx_enable, o_pkt_ready, o_pkt_len, i_rd_addr, o_rd_data,
// i_pkt_ack, o_csum_err, o_drop_cnt.
module rx_pkt_ctrl
   import rx_pkt_ctrl_pkg::*;
#(
   parameter logic [7:0] HEADER  = HEADER_DEF,
   parameter int         MAX_LEN = 16,
   parameter int         TIMEOUT = 1000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [BYTE_W-1:0] i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_rx_err,
   output logic              o_rx_enable,
   output logic              o_pkt_ready,
   output logic [LEN_W-1:0]  o_pkt_len,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [BYTE_W-1:0] o_rd_data,
   input  logic              i_pkt_ack,
   output logic              o_csum_err,
   output logic [7:0]        o_drop_cnt
);

   localparam int          TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0]  MAX_B    = 8'(MAX_LEN);

   state_t             r_state, w_state_nxt;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_idx;
   logic [BYTE_W-1:0]  r_sum;
   logic [TW-1:0]      r_tmo;
   logic [7:0]         r_drop;
   logic               r_csum_err;

   logic w_drop, w_cerr, w_wr, w_len_ld, w_tmo, w_byte, w_active;

   assign w_byte   = i_rx_valid & ~i_rx_err;
   assign w_active = (r_state == S_LEN) || (r_state == S_PAYLOAD) ||
                     (r_state == S_CSUM);
   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign w_tmo    = ~i_rx_valid & (r_tmo == TMO_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_drop      = 1'b0;
      w_cerr      = 1'b0;
      w_wr        = 1'b0;
      w_len_ld    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_byte && i_rx_data == HEADER) w_state_nxt = S_LEN;
         end
         S_LEN: begin
            if (i_rx_err || (!i_rx_valid && w_tmo)) begin
               w_state_nxt = S_IDLE;
               w_drop      = 1'b1;
            end else if (i_rx_valid) begin
               if (i_rx_data > MAX_B) begin
                  w_state_nxt = S_IDLE;
                  w_drop      = 1'b1;
               end else begin
                  w_len_ld    = 1'b1;
                  w_state_nxt = (i_rx_data == '0) ? S_CSUM : S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (i_rx_err || (!i_rx_valid && w_tmo)) begin
               w_state_nxt = S_IDLE;
               w_drop      = 1'b1;
            end else if (i_rx_valid) begin
               w_wr = 1'b1;
               if (r_idx == r_len - 5'd1) w_state_nxt = S_CSUM;
            end
         end
         S_CSUM: begin
            if (i_rx_err || (!i_rx_valid && w_tmo)) begin
               w_state_nxt = S_IDLE;
               w_drop      = 1'b1;
            end else if (i_rx_valid) begin
               if (i_rx_data == r_sum) begin
                  w_state_nxt = S_HOLD;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_cerr      = 1'b1;
                  w_drop      = 1'b1;
               end
            end
         end
         S_HOLD: begin
            // Receiver overrun: byte is lost but counted.
            if (i_rx_valid) w_drop = 1'b1;
            if (i_pkt_ack)  w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_len      <= '0;
         r_idx      <= '0;
         r_sum      <= '0;
         r_tmo      <= '0;
         r_drop     <= '0;
         r_csum_err <= 1'b0;
      end else begin
         r_csum_err <= w_cerr;
         if (w_drop) r_drop <= sat_inc8(r_drop);
         if (w_len_ld) begin
            r_len <= i_rx_data[LEN_W-1:0];
            r_sum <= i_rx_data;
            r_idx <= '0;
         end
         if (w_wr) begin
            r_sum <= r_sum + i_rx_data;
            r_idx <= r_idx + 5'd1;
         end
         if (!w_active || i_rx_valid || w_state_nxt == S_IDLE)
            r_tmo <= '0;
         else if (r_tmo != TMO_LAST)
            r_tmo <= r_tmo + 1'b1;
      end
   end

   rx_pkt_buf #(.DEPTH(MAX_LEN)) u_buf (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_wr_en   (w_wr),
      .i_wr_addr (r_idx[ADDR_W-1:0]),
      .i_wr_data (i_rx_data),
      .i_rd_addr (i_rd_addr),
      .o_rd_data (o_rd_data)
   );

   assign o_rx_enable = (r_state != S_HOLD);
   assign o_pkt_ready = (r_state == S_HOLD);
   assign o_pkt_len   = r_len;
   assign o_csum_err  = r_csum_err;
   assign o_drop_cnt  = r_drop;

endmodule
